// File: rtl/sram_like_bridge.sv
// Bridges the core's single-cycle SRAM-style port to a req/addr_ok/data_ok bus.
// Generates byte lanes, right-aligns read data, and flags misaligned requests.
module sram_like_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   localparam int NBYTES = DATA_W / 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [1:0]        cpu_size,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   output logic              cpu_addr_err,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [1:0]        bus_size,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [NBYTES-1:0] bus_wstrb,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam int OFF_W = $clog2(NBYTES);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t state_q, state_d;

   logic [OFF_W-1:0]  req_off;
   logic [3:0]        req_nbytes;
   logic [OFF_W-1:0]  align_mask;
   logic              size_bad;
   logic              misaligned;
   logic [NBYTES-1:0] req_strb;
   logic [DATA_W-1:0] req_wdata;
   logic [OFF_W-1:0]  lat_off;
   logic [3:0]        lat_nbytes;
   logic [DATA_W-1:0] rd_shifted;
   logic [DATA_W-1:0] cap_rdata;
   logic              accept;
   logic              capture;
   logic              stall;
   logic              addr_err;

   function automatic logic [NBYTES-1:0] lanes(input logic [3:0] nb);
      logic [NBYTES-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < NBYTES; i++) m[i] = (i < 32'(nb));
      return m;
   endfunction

   always_comb begin
      req_off    = cpu_addr[OFF_W-1:0];
      req_nbytes = 4'd1 << cpu_size;
      align_mask = OFF_W'(req_nbytes - 4'd1);
      size_bad   = (32'(cpu_size) > OFF_W);
      misaligned = size_bad || ((req_off & align_mask) != '0);
      req_strb   = lanes(req_nbytes) << req_off;
      req_wdata  = cpu_wdata << {req_off, 3'b000};

      // Read return uses the latched request, since cpu_addr may not be trusted here
      lat_off    = bus_addr[OFF_W-1:0];
      lat_nbytes = 4'd1 << bus_size;
      rd_shifted = bus_rdata >> {lat_off, 3'b000};
      cap_rdata  = '0;
      for (int unsigned i = 0; i < NBYTES; i++) begin
         if (i < 32'(lat_nbytes)) cap_rdata[8*i +: 8] = rd_shifted[8*i +: 8];
      end
   end

   always_comb begin
      state_d  = state_q;
      stall    = 1'b0;
      addr_err = 1'b0;
      accept   = 1'b0;
      capture  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               if (misaligned) begin
                  addr_err = 1'b1;
               end else begin
                  stall   = 1'b1;
                  accept  = 1'b1;
                  state_d = ADDR;
               end
            end
         end
         ADDR: begin
            stall = 1'b1;
            if (bus_addr_ok) begin
               if (bus_data_ok) begin
                  capture = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            stall = 1'b1;
            if (bus_data_ok) begin
               capture = 1'b1;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Combinational outputs are forced low while reset is held
   assign cpu_stall    = stall & resetn;
   assign cpu_addr_err = addr_err & resetn;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         bus_req   <= 1'b0;
         bus_wr    <= 1'b0;
         bus_size  <= '0;
         bus_addr  <= '0;
         bus_wstrb <= '0;
         bus_wdata <= '0;
         cpu_rdata <= '0;
      end else begin
         state_q <= state_d;
         bus_req <= (state_d == ADDR);
         if (accept) begin
            bus_wr    <= cpu_wr;
            bus_size  <= cpu_size;
            bus_addr  <= cpu_addr;
            bus_wstrb <= req_strb;
            bus_wdata <= req_wdata;
         end
         if (capture) cpu_rdata <= cap_rdata;
      end
   end

endmodule

// File: tb/tb_sram_like_bridge.sv
// Randomized self-checking bench for sram_like_bridge (32-bit and 64-bit instances)
// against a byte-level reference model.
module tb_sram_like_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetn;

   logic        cpu_req, cpu_wr, cpu_stall, cpu_addr_err;
   logic [1:0]  cpu_size;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_wstrb;

   logic        w_cpu_req, w_cpu_wr, w_cpu_stall, w_cpu_addr_err;
   logic [1:0]  w_cpu_size;
   logic [31:0] w_cpu_addr;
   logic [63:0] w_cpu_wdata, w_cpu_rdata;
   logic        w_bus_req, w_bus_wr, w_bus_addr_ok, w_bus_data_ok;
   logic [1:0]  w_bus_size;
   logic [31:0] w_bus_addr;
   logic [63:0] w_bus_wdata, w_bus_rdata;
   logic [7:0]  w_bus_wstrb;

   sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) u32 (
      .clk(clk), .resetn(resetn),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .cpu_addr_err(cpu_addr_err), .bus_req(bus_req), .bus_wr(bus_wr),
      .bus_size(bus_size), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
      .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
      .bus_rdata(bus_rdata)
   );

   sram_like_bridge #(.ADDR_W(32), .DATA_W(64)) u64 (
      .clk(clk), .resetn(resetn),
      .cpu_req(w_cpu_req), .cpu_wr(w_cpu_wr), .cpu_size(w_cpu_size), .cpu_addr(w_cpu_addr),
      .cpu_wdata(w_cpu_wdata), .cpu_rdata(w_cpu_rdata), .cpu_stall(w_cpu_stall),
      .cpu_addr_err(w_cpu_addr_err), .bus_req(w_bus_req), .bus_wr(w_bus_wr),
      .bus_size(w_bus_size), .bus_addr(w_bus_addr), .bus_wstrb(w_bus_wstrb),
      .bus_wdata(w_bus_wdata), .bus_addr_ok(w_bus_addr_ok), .bus_data_ok(w_bus_data_ok),
      .bus_rdata(w_bus_rdata)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] last_rdata;
   bit          last_valid;

   // Reference model for the 32-bit port, in plain byte arithmetic
   function automatic bit m_err(input logic [1:0] size, input logic [31:0] addr);
      if (size == 2'd3) return 1'b1;
      return (addr % (32'd1 << size)) != 32'd0;
   endfunction

   function automatic logic [3:0] m_strb(input logic [1:0] size, input logic [31:0] addr);
      int off, nb;
      logic [3:0] s;
      off = int'(addr % 32'd4);
      nb  = 1 << size;
      s   = '0;
      for (int i = 0; i < 4; i++) if (i >= off && i < off + nb) s[i] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [31:0] wdata, input logic [31:0] addr);
      logic [63:0] t;
      t = {32'd0, wdata} << (8 * (addr % 32'd4));
      return t[31:0];
   endfunction

   function automatic logic [31:0] m_rdata(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [1:0] size);
      logic [31:0] v;
      v = rdata >> (8 * (addr % 32'd4));
      if (size < 2'd2) v = v & ((32'd1 << (8 << size)) - 32'd1);
      return v;
   endfunction

   task automatic run_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int addr_wait, input int data_wait, input bit same,
                          input string tag, output int stall_n, output int req_n);
      logic [3:0]  e_strb;
      logic [31:0] e_wdata, e_rdata;
      int phase, n_a, n_d;
      bit done;
      e_strb  = m_strb(size, addr);
      e_wdata = m_wdata(wdata, addr);
      e_rdata = m_rdata(rdata, addr, size);
      @(negedge clk);
      cpu_req = 1'b1; cpu_wr = wr; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = $urandom;
      #1;
      n_cmp++;
      if ({cpu_stall, cpu_addr_err, bus_req} !== 3'b100) begin
         n_bad++;
         $display("FAIL %s accept: stall/err/req=%b expected 100", tag, {cpu_stall, cpu_addr_err, bus_req});
      end
      stall_n = cpu_stall ? 1 : 0;
      req_n = 0; phase = 0; n_a = 0; n_d = 0; done = 1'b0;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         @(negedge clk);
         bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = $urandom;
         if (phase == 2) begin
            #1;
            n_cmp++;
            if (cpu_stall !== 1'b0 || bus_req !== 1'b0) begin
               n_bad++;
               $display("FAIL %s done: stall=%b req=%b expected 0 0", tag, cpu_stall, bus_req);
            end
            if (!wr) begin
               n_cmp++;
               if (cpu_rdata !== e_rdata) begin
                  n_bad++;
                  $display("FAIL %s rdata: got %h expected %h", tag, cpu_rdata, e_rdata);
               end
            end
            last_rdata = e_rdata;
            last_valid = !wr;
            done = 1'b1;
         end else begin
            req_n += (bus_req === 1'b1) ? 1 : 0;
            if (phase == 0) begin
               n_cmp++;
               if ({bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata} !==
                   {1'b1, wr, size, addr, e_strb, e_wdata}) begin
                  n_bad++;
                  $display("FAIL %s addr_phase: req=%b wr=%b size=%0d addr=%h strb=%b wdata=%h expected 1 %b %0d %h %b %h",
                           tag, bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
                           wr, size, addr, e_strb, e_wdata);
               end
               if (n_a == addr_wait) begin
                  bus_addr_ok = 1'b1;
                  if (same) begin
                     bus_data_ok = 1'b1; bus_rdata = rdata; phase = 2;
                  end else begin
                     phase = 1;
                  end
               end else begin
                  n_a++;
               end
            end else begin
               n_cmp++;
               if (bus_req !== 1'b0) begin
                  n_bad++;
                  $display("FAIL %s data_phase_req: got %b expected 0", tag, bus_req);
               end
               if (n_d == data_wait) begin
                  bus_data_ok = 1'b1; bus_rdata = rdata; phase = 2;
               end else begin
                  n_d++;
               end
            end
            #1;
            stall_n += (cpu_stall === 1'b1) ? 1 : 0;
            n_cmp++;
            if (cpu_stall !== 1'b1) begin
               n_bad++;
               $display("FAIL %s busy_stall: got %b expected 1", tag, cpu_stall);
            end
            if (last_valid) begin
               n_cmp++;
               if (cpu_rdata !== last_rdata) begin
                  n_bad++;
                  $display("FAIL %s rdata_hold: got %h expected %h", tag, cpu_rdata, last_rdata);
               end
            end
         end
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL %s timeout: done=0 expected 1", tag);
      end
   endtask

   // Drop the request and offer a stray data_ok, which must be ignored
   task automatic idle_cycle(input string tag);
      @(negedge clk);
      cpu_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = $urandom;
      #1;
      n_cmp++;
      if ({cpu_stall, cpu_addr_err, bus_req} !== 3'b000) begin
         n_bad++;
         $display("FAIL %s idle: stall/err/req=%b expected 000", tag, {cpu_stall, cpu_addr_err, bus_req});
      end
      @(negedge clk);
      bus_data_ok = 1'b0;
      #1;
      if (last_valid) begin
         n_cmp++;
         if (cpu_rdata !== last_rdata) begin
            n_bad++;
            $display("FAIL %s idle_hold: got %h expected %h", tag, cpu_rdata, last_rdata);
         end
      end
   endtask

   task automatic check_err(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input string tag);
      @(negedge clk);
      cpu_req = 1'b1; cpu_wr = wr; cpu_size = size; cpu_addr = addr; cpu_wdata = $urandom;
      #1;
      n_cmp++;
      if ({cpu_stall, cpu_addr_err, bus_req} !== 3'b010) begin
         n_bad++;
         $display("FAIL %s err_pulse: stall/err/req=%b expected 010", tag, {cpu_stall, cpu_addr_err, bus_req});
      end
      @(negedge clk);
      cpu_req = 1'b0;
      #1;
      n_cmp++;
      if ({cpu_stall, cpu_addr_err, bus_req} !== 3'b000) begin
         n_bad++;
         $display("FAIL %s err_after: stall/err/req=%b expected 000", tag, {cpu_stall, cpu_addr_err, bus_req});
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      cpu_req = 1'b0; cpu_wr = 1'b0; cpu_size = 2'd0; cpu_addr = '0; cpu_wdata = '0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
      w_cpu_req = 1'b0; w_cpu_wr = 1'b0; w_cpu_size = 2'd0; w_cpu_addr = '0; w_cpu_wdata = '0;
      w_bus_addr_ok = 1'b0; w_bus_data_ok = 1'b0; w_bus_rdata = '0;
      last_rdata = '0; last_valid = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({cpu_rdata, cpu_stall, cpu_addr_err, bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata} !== '0) begin
         n_bad++;
         $display("FAIL reset32: rdata=%h stall=%b req=%b addr=%h strb=%b expected all 0",
                  cpu_rdata, cpu_stall, bus_req, bus_addr, bus_wstrb);
      end
      n_cmp++;
      if ({w_cpu_rdata, w_cpu_stall, w_cpu_addr_err, w_bus_req, w_bus_wr, w_bus_size, w_bus_addr, w_bus_wstrb, w_bus_wdata} !== '0) begin
         n_bad++;
         $display("FAIL reset64: rdata=%h stall=%b req=%b strb=%b expected all 0",
                  w_cpu_rdata, w_cpu_stall, w_bus_req, w_bus_wstrb);
      end
      resetn = 1'b1;
   endtask

   task automatic test_word_load();
      int s, r;
      run_txn(1'b0, 2'd2, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, "word_load", s, r);
      n_cmp++;
      if (s != 3 || r != 1) begin
         n_bad++;
         $display("FAIL word_load_timing: stall_cycles=%0d req_cycles=%0d expected 3 1", s, r);
      end
      idle_cycle("word_load");
   endtask

   task automatic test_byte_store();
      int s, r;
      run_txn(1'b1, 2'd0, 32'h1003, 32'h000000A5, $urandom, 0, 1, 1'b0, "byte_store", s, r);
      idle_cycle("byte_store");
   endtask

   task automatic test_half_load_wait();
      int s, r;
      run_txn(1'b0, 2'd1, 32'h2002, 32'h0, 32'h1234ABCD, 4, 0, 1'b0, "half_load", s, r);
      n_cmp++;
      if (s != 7 || r != 5) begin
         n_bad++;
         $display("FAIL half_load_timing: stall_cycles=%0d req_cycles=%0d expected 7 5", s, r);
      end
      idle_cycle("half_load");
   endtask

   task automatic test_addr_err();
      check_err(1'b1, 2'd2, 32'h3001, "mis_word_store");
      check_err(1'b0, 2'd3, 32'h0000, "size3_on_32");
      check_err(1'b0, 2'd1, 32'h0005, "mis_half_load");
   endtask

   task automatic test_dw64();
      logic [1:0]  sz [2];
      logic [31:0] ad [2];
      logic [63:0] r, e_r;
      logic [7:0]  e_s;
      sz[0] = 2'd3; ad[0] = 32'h08;
      sz[1] = 2'd2; ad[1] = 32'h0C;
      for (int k = 0; k < 2; k++) begin
         r   = {$urandom, $urandom};
         e_s = (k == 0) ? 8'hFF : 8'hF0;
         e_r = (k == 0) ? r : {32'd0, r[63:32]};
         @(negedge clk);
         w_cpu_req = 1'b1; w_cpu_wr = 1'b0; w_cpu_size = sz[k]; w_cpu_addr = ad[k];
         @(negedge clk);
         n_cmp++;
         if (w_bus_req !== 1'b1 || w_bus_wstrb !== e_s || w_bus_wr !== 1'b0) begin
            n_bad++;
            $display("FAIL dw64_strb%0d: req=%b strb=%h wr=%b expected 1 %h 0", k, w_bus_req, w_bus_wstrb, w_bus_wr, e_s);
         end
         w_bus_addr_ok = 1'b1;
         @(negedge clk);
         w_bus_addr_ok = 1'b0; w_bus_data_ok = 1'b1; w_bus_rdata = r;
         @(negedge clk);
         w_bus_data_ok = 1'b0; w_bus_rdata = '0;
         #1;
         n_cmp++;
         if (w_cpu_stall !== 1'b0 || w_cpu_rdata !== e_r) begin
            n_bad++;
            $display("FAIL dw64_rdata%0d: stall=%b rdata=%h expected 0 %h", k, w_cpu_stall, w_cpu_rdata, e_r);
         end
         @(negedge clk);
         w_cpu_req = 1'b0;
      end
   endtask

   task automatic test_same_cycle();
      int s, r;
      run_txn(1'b0, 2'd0, 32'h5002, 32'h0, $urandom, 2, 0, 1'b1, "same_cycle", s, r);
      n_cmp++;
      if (s != 4) begin
         n_bad++;
         $display("FAIL same_cycle_timing: stall_cycles=%0d expected 4", s);
      end
      idle_cycle("same_cycle");
   endtask

   task automatic test_reset_mid();
      int s, r;
      @(negedge clk);
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_size = 2'd2; cpu_addr = 32'h4000; cpu_wdata = $urandom;
      @(negedge clk);
      bus_addr_ok = 1'b1;
      @(negedge clk);
      bus_addr_ok = 1'b0;
      #1;
      n_cmp++;
      if (cpu_stall !== 1'b1 || bus_req !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_in_data: stall=%b req=%b expected 1 0", cpu_stall, bus_req);
      end
      #1 resetn = 1'b0;
      #1;
      n_cmp++;
      if ({cpu_rdata, cpu_stall, cpu_addr_err, bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata} !== '0) begin
         n_bad++;
         $display("FAIL mid_reset: rdata=%h stall=%b req=%b wr=%b addr=%h strb=%b wdata=%h expected all 0",
                  cpu_rdata, cpu_stall, bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata);
      end
      @(negedge clk);
      cpu_req = 1'b0; resetn = 1'b1;
      last_rdata = '0; last_valid = 1'b1;
      run_txn(1'b0, 2'd2, 32'h4004, 32'h0, $urandom, 1, 1, 1'b0, "after_reset", s, r);
      idle_cycle("after_reset");
   endtask

   task automatic test_back_to_back();
      int s, r;
      run_txn(1'b0, 2'd2, 32'h6000, 32'h0, $urandom, 0, 0, 1'b0, "b2b_first", s, r);
      run_txn(1'b1, 2'd1, 32'h6006, $urandom, $urandom, 0, 0, 1'b0, "b2b_second", s, r);
      run_txn(1'b0, 2'd0, 32'h6001, 32'h0, $urandom, 0, 0, 1'b1, "b2b_third", s, r);
      idle_cycle("b2b");
   endtask

   task automatic test_random();
      logic [1:0]  size;
      logic [31:0] addr;
      int s, r;
      for (int k = 0; k < 40; k++) begin
         size = 2'($urandom_range(0, 3));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0 && size != 2'd3) addr = addr & ~((32'd1 << size) - 32'd1);
         if (m_err(size, addr)) begin
            check_err(1'($urandom_range(0, 1)), size, addr, "rand_err");
         end else begin
            run_txn(1'($urandom_range(0, 1)), size, addr, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    "rand_txn", s, r);
            if ($urandom_range(0, 1) != 0) idle_cycle("rand_idle");
         end
      end
      idle_cycle("rand_end");
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_byte_store();
      test_half_load_wait();
      test_addr_err();
      test_dw64();
      test_same_cycle();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sram_like_bridge.md
Name: sram_like_bridge

Overview:
Parametrised bridge between the core's single-cycle SRAM-style memory port and a handshaked sram-like bus (req/addr_ok/data_ok). The top level instantiates it twice, once for instruction fetch and once for data. It replaces the fixed en/wen wiring at the top level, which assumed zero-wait memory. It adds:
- byte-lane generation from access size and address,
- right-aligned read-data return,
- misalignment detection,
- a stall output that freezes the pipeline while a bus transaction is outstanding.

Parameters:
ADDR_W, 32, address width in bits.
DATA_W, 32, bus data width; 32 or 64.
NBYTES, DATA_W/8, derived; byte lanes per beat (not overridable).

Ports:
clk  in  1  clock, rising edge.
resetn  in  1  asynchronous reset, active-low.
cpu_req  in  1  access request; held stable by the core while cpu_stall=1.
cpu_wr  in  1  1=store, 0=load.
cpu_size  in  2  log2(bytes): 0=byte, 1=half, 2=word, 3=dword (dword valid only if DATA_W=64).
cpu_addr  in  ADDR_W  byte address.
cpu_wdata  in  DATA_W  store data, right-aligned.
cpu_rdata  out  DATA_W  load data, right-aligned, upper bits zero; valid when cpu_stall=0 in DONE.
cpu_stall  out  1  pipeline freeze.
cpu_addr_err  out  1  misaligned or illegal-size request, one-cycle pulse.
bus_req  out  1  address-phase request.
bus_wr  out  1  write flag.
bus_size  out  2  copy of latched cpu_size.
bus_addr  out  ADDR_W  latched byte address.
bus_wstrb  out  NBYTES  byte enables.
bus_wdata  out  DATA_W  store data shifted to lane position.
bus_addr_ok  in  1  address accepted.
bus_data_ok  in  1  data phase complete; bus_rdata valid.
bus_rdata  in  DATA_W  read data, lane-positioned.

Behaviour:
- Reset: all outputs 0; state=IDLE; latch registers 0. Reset asserted mid-transaction aborts immediately and returns to IDLE.
- FSM states: IDLE, ADDR, DATA, DONE.

IDLE
- cpu_req=0: stay in IDLE, cpu_stall=0.
- cpu_req=1 and misaligned: cpu_addr_err=1 this cycle; cpu_stall=0; no bus activity; stay in IDLE. Misaligned means addr[size-1:0]!=0, or size > log2(NBYTES).
- cpu_req=1 and aligned: latch wr, size, addr, wstrb, shifted wdata; cpu_stall=1; go to ADDR.

ADDR
- bus_req=1; bus_* outputs driven from the latch registers; cpu_stall=1.
- On bus_addr_ok, go to DATA.
- If bus_addr_ok and bus_data_ok arrive together, capture rdata and go straight to DONE.

DATA
- bus_req=0; cpu_stall=1.
- On bus_data_ok, capture rdata and go to DONE.

DONE
- cpu_stall=0; cpu_rdata driven from the capture register; go to IDLE next cycle unconditionally.
- The still-asserted cpu_req in this cycle is the same request, not a new one, and must not be reissued.

Lane and data rules:
- off = addr[log2(NBYTES)-1:0].
- wstrb = ((1<<(1<<size))-1) << off.
- bus_wdata = cpu_wdata << (8*off).
- cpu_rdata = (bus_rdata >> (8*off)) masked to (1<<size) bytes.
- Loads: wstrb is still generated, but bus_wr=0.

Timing and stability:
- Minimum latency with zero-wait slave (addr_ok in first ADDR cycle, data_ok next cycle): request cycle plus 3 cycles; cpu_stall high for 3 cycles.
- bus_req, bus_addr, bus_wr, bus_size, bus_wstrb and bus_wdata are all registered and stable for the whole of ADDR.
- cpu_rdata holds its last captured value outside DONE.
- Address error on a store: nothing written; bus_req stays 0.
- bus_data_ok in IDLE or DONE is ignored.

Test Plan:
1. Aligned word load, DATA_W=32, addr=0x1000. Slave gives addr_ok in the first ADDR cycle and data_ok one cycle later with rdata=0xDEADBEEF. Expect: stall high for 3 cycles; cpu_rdata=0xDEADBEEF in DONE; bus_req high exactly 1 cycle.
2. Byte store, addr=0x1003, wdata=0x000000A5. Expect: wstrb=4'b1000, bus_wdata=0xA5000000, bus_wr=1; stall released after data_ok.
3. Half load, addr=0x2002, bus_rdata=0x1234ABCD. Expect: wstrb=4'b1100, cpu_rdata=0x00001234. Slave delays addr_ok by 4 cycles; stall stays high throughout, and bus_addr/bus_req are stable.
4. Misaligned word store to 0x3001, and size=3 with DATA_W=32. Expect: single-cycle cpu_addr_err, stall=0, bus_req never asserted.
5. DATA_W=64: dword load at 0x08 gives wstrb=8'hFF; word load at 0x0C gives wstrb=8'hF0 and cpu_rdata=bus_rdata[63:32].
6. Combined and boundary cases:
   - addr_ok and data_ok in the same cycle → DONE next cycle.
   - resetn pulled low while in DATA → all outputs 0 asynchronously, state IDLE; a fresh request afterward completes normally.
   - Back-to-back requests: the new request is accepted on the cycle after DONE.
